iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (range 4..32).
REQ-002 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request operands/op_code valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port input1  input  WIDTH  operand A (dividend for div/mod).
REQ-008 SHALL have port input2  input  WIDTH  operand B (divisor for div/mod).
REQ-009 SHALL have port op_code  input  4  0 add, 1 sub, 2 mul, 3 div, 4 mod, 5..15 invalid.
REQ-010 SHALL have port out_valid  output  1  output1/err_code valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port output1  output  2*WIDTH  result, sign-extended when SIGNED=1, zero-extended otherwise.
REQ-013 SHALL have port err_code  output  2  bit0 add/sub exceeds WIDTH range, bit1 divide-by-zero; 2'b11 invalid op_code.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-015 SHALL capture input1, input2, op_code on the edge where in_valid && in_ready; later input changes have no effect.
REQ-016 Add/sub SHALL go IDLE -> DONE directly; out_valid rises 1 cycle after accept.
REQ-017 Add/sub output1 SHALL be the exact (WIDTH+1)-bit result extended to 2*WIDTH; err_code[0]=1 when it does not fit in WIDTH bits of the selected signedness.
REQ-018 Mul SHALL use iterative shift-add, one multiplier bit per cycle, WIDTH cycles in CALC; out_valid rises WIDTH+1 cycles after accept; output1 = exact 2*WIDTH-bit product; err_code=2'b00.
REQ-019 Div/mod SHALL use iterative restoring shift-subtract on magnitudes, WIDTH cycles in CALC; out_valid rises WIDTH+1 cycles after accept.
REQ-020 Signed div SHALL truncate toward zero; signed mod SHALL take the sign of the dividend; -2^(WIDTH-1)/-1 SHALL yield +2^(WIDTH-1) in output1 with err_code=2'b00.
REQ-021 Divisor 0 (div or mod) SHALL skip CALC: out_valid 1 cycle after accept, output1=0, err_code=2'b10.
REQ-022 Invalid op_code SHALL skip CALC: out_valid 1 cycle after accept, output1=0, err_code=2'b11.
REQ-023 In DONE, output1/err_code/out_valid SHALL hold stable until out_valid && out_ready; FSM returns to IDLE on that edge.
REQ-024 in_ready SHALL be 1 the cycle after the output handshake; no request is accepted in the handshake cycle itself (one request in flight max).
REQ-025 output1 and err_code SHALL not change while out_valid=0 except via reset (value undefined-free, holds last result).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, out_valid=0, output1=0, err_code=2'b00, in_ready=1 after release, iteration counter 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation; no out_valid for it after release.

Structure
REQ-028 SHALL place the op_code constants, err_code constants and FSM state type in shared package alu_pkg.
REQ-029 SHALL instantiate one sub-module iter_divider (magnitude restoring divider, start/done, quotient+remainder); multiplier, add/sub and sign fix-up stay in iter_alu.
REQ-030 SHALL use a single $clog2(WIDTH+1)-bit iteration counter shared by mul and div.

Verification (WIDTH=16, SIGNED=1 unless noted)
REQ-031 mul 11*15, out_ready=1 -> out_valid exactly 17 cycles after accept, output1=165, err=00.
REQ-032 add 32000+16000 -> output1=48000, err=01, 1-cycle latency; sub 11-15 -> output1=-4, err=00.
REQ-033 div -7/2 -> -3; mod -7/2 -> -1; div -32768/-1 -> 32768, err=00; SIGNED=0 div 65535/2 -> 32767.
REQ-034 div 11/0 and op_code 7 -> output1=0, err=10 and 11 respectively, out_valid 1 cycle after accept.
REQ-035 mul 32000*16000 with out_ready held 0 for 5 cycles -> output1=512000000 stable throughout, in_ready=0 until handshake, then 1.
REQ-036 rst_n pulsed low 4 cycles into a mul -> out_valid=0, output1=0 immediately; next add 1+2 -> 3 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the iterative ALU: op codes, error codes and FSM states.
// The state encoding lives here so the top and any future debug logic agree on it.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;
    localparam logic [1:0] ERR_INV  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU; master drives requests, slave is the ALU.
interface iter_alu_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       input1;
    logic [WIDTH-1:0]       input2;
    logic [3:0]             op_code;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     output1;
    logic [1:0]             err_code;

    modport master (
        output in_valid, input1, input2, op_code, out_ready,
        input  in_ready, out_valid, output1, err_code
    );

    modport slave (
        input  in_valid, input1, input2, op_code, out_ready,
        output in_ready, out_valid, output1, err_code
    );
endinterface

// File: rtl/iter_divider.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit per step.
// Iteration count is owned by the caller; quot_o/rem_o show the values after the current step.
module iter_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // The partial remainder is always below the divisor, so the top bit of trial is its sign.
    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_q};
        fits    = ~trial[WIDTH];
        quot_d  = {quot_q[WIDTH-2:0], fits};
        rem_d   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else if (start_i) begin
            quot_q    <= dividend_i;
            rem_q     <= '0;
            divisor_q <= divisor_i;
        end else if (step_i) begin
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

    assign done_o = step_i && last_i;
    assign quot_o = quot_d;
    assign rem_o  = rem_d;

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle add/sub, shift-add multiply and restoring divide/modulo
// behind a one-in-flight valid/ready handshake.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    iter_alu_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic                 resultNeg_q, resultNeg_d;
    logic                 dividendNeg_q, dividendNeg_d;
    logic [WIDTH-1:0]     magA_q, magA_d;
    logic [2*WIDTH:0]     mulAcc_q, mulAcc_d;
    logic [2*WIDTH-1:0]   output1_q, output1_d;
    logic [1:0]           err_q, err_d;

    logic                 aNeg, bNeg;
    logic [WIDTH-1:0]     magA, magB;
    logic [WIDTH:0]       extA, extB, addRes;
    logic                 addOvf;
    logic [2*WIDTH-1:0]   addExt;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH:0]     mulNext;
    logic [2*WIDTH-1:0]   mulFinal;
    logic [WIDTH-1:0]     divRes;
    logic [2*WIDTH-1:0]   divExt, divFinal;
    logic                 divNeg;
    logic                 lastIter;
    logic                 divStart, divStep, divDone;
    logic [WIDTH-1:0]     quot, rem;

    assign aNeg = (SIGNED != 0) && bus.input1[WIDTH-1];
    assign bNeg = (SIGNED != 0) && bus.input2[WIDTH-1];
    assign magA = aNeg ? (~bus.input1 + WIDTH'(1)) : bus.input1;
    assign magB = bNeg ? (~bus.input2 + WIDTH'(1)) : bus.input2;

    // Add/sub is done one bit wider than the operands so the result is always exact.
    always_comb begin
        extA   = (SIGNED != 0) ? {bus.input1[WIDTH-1], bus.input1} : {1'b0, bus.input1};
        extB   = (SIGNED != 0) ? {bus.input2[WIDTH-1], bus.input2} : {1'b0, bus.input2};
        addRes = (bus.op_code == OP_SUB) ? (extA - extB) : (extA + extB);
        addOvf = (SIGNED != 0) ? (addRes[WIDTH] ^ addRes[WIDTH-1]) : addRes[WIDTH];
        addExt = (SIGNED != 0) ? {{(WIDTH-1){addRes[WIDTH]}}, addRes}
                               : {{(WIDTH-1){1'b0}}, addRes};
    end

    always_comb begin
        mulSum   = mulAcc_q[2*WIDTH:WIDTH] + (mulAcc_q[0] ? {1'b0, magA_q} : '0);
        mulNext  = {1'b0, mulSum, mulAcc_q[WIDTH-1:1]};
        mulFinal = resultNeg_q ? (~mulNext[2*WIDTH-1:0] + (2*WIDTH)'(1)) : mulNext[2*WIDTH-1:0];
        divRes   = (op_q == OP_DIV) ? quot : rem;
        divNeg   = (op_q == OP_DIV) ? resultNeg_q : dividendNeg_q;
        divExt   = {{WIDTH{1'b0}}, divRes};
        divFinal = divNeg ? (~divExt + (2*WIDTH)'(1)) : divExt;
    end

    assign lastIter = (cnt_q == CW'(WIDTH - 1));

    iter_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (divStart),
        .step_i     (divStep),
        .last_i     (lastIter),
        .dividend_i (magA),
        .divisor_i  (magB),
        .done_o     (divDone),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        resultNeg_d   = resultNeg_q;
        dividendNeg_d = dividendNeg_q;
        magA_d        = magA_q;
        mulAcc_d      = mulAcc_q;
        output1_d     = output1_q;
        err_d         = err_q;
        divStart      = 1'b0;
        divStep       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d          = bus.op_code;
                    resultNeg_d   = aNeg ^ bNeg;
                    dividendNeg_d = aNeg;
                    cnt_d         = '0;
                    case (bus.op_code)
                        OP_ADD, OP_SUB: begin
                            output1_d = addExt;
                            err_d     = addOvf ? ERR_OVF : ERR_NONE;
                            state_d   = ST_DONE;
                        end
                        OP_MUL: begin
                            magA_d   = magA;
                            mulAcc_d = {{(WIDTH+1){1'b0}}, magB};
                            state_d  = ST_CALC;
                        end
                        OP_DIV, OP_MOD: begin
                            if (bus.input2 == '0) begin
                                output1_d = '0;
                                err_d     = ERR_DIV0;
                                state_d   = ST_DONE;
                            end else begin
                                divStart = 1'b1;
                                state_d  = ST_CALC;
                            end
                        end
                        default: begin
                            output1_d = '0;
                            err_d     = ERR_INV;
                            state_d   = ST_DONE;
                        end
                    endcase
                end
            end
            ST_CALC: begin
                cnt_d = lastIter ? '0 : cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    mulAcc_d = mulNext;
                    if (lastIter) begin
                        output1_d = mulFinal;
                        err_d     = ERR_NONE;
                        state_d   = ST_DONE;
                    end
                end else begin
                    divStep = 1'b1;
                    if (divDone) begin
                        output1_d = divFinal;
                        err_d     = ERR_NONE;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            resultNeg_q   <= 1'b0;
            dividendNeg_q <= 1'b0;
            magA_q        <= '0;
            mulAcc_q      <= '0;
            output1_q     <= '0;
            err_q         <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            resultNeg_q   <= resultNeg_d;
            dividendNeg_q <= dividendNeg_d;
            magA_q        <= magA_d;
            mulAcc_q      <= mulAcc_d;
            output1_q     <= output1_d;
            err_q         <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.output1   = output1_q;
    assign bus.err_code  = err_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: reference model built on plain integer arithmetic,
// a per-cycle compare process, and literal expectations for the hand-worked cases.
module tb_iter_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] o;
        logic [1:0]  e;
        int          acc;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    exp_t        expQ[$];
    logic [31:0] lastOut;
    logic [1:0]  lastErr;
    bit          sawValid;

    iter_alu_if #(.WIDTH(16)) ifS ();
    iter_alu_if #(.WIDTH(16)) ifU ();

    iter_alu #(.WIDTH(16), .SIGNED(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifS)
    );

    iter_alu #(.WIDTH(16), .SIGNED(0)) dutU (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Result = {err, output1} derived directly from the arithmetic definition.
    function automatic logic [33:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input bit s);
        longint sa, sb, r;
        logic [31:0] o;
        logic [1:0]  e;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        o = '0;
        e = 2'b00;
        r = 0;
        case (op)
            OP_ADD, OP_SUB: begin
                r = (op == OP_ADD) ? sa + sb : sa - sb;
                if (s) e = (r < -32768 || r > 32767) ? 2'b01 : 2'b00;
                else   e = (r < 0 || r > 65535) ? 2'b01 : 2'b00;
                o = s ? r[31:0] : {15'b0, r[16:0]};
            end
            OP_MUL: begin
                r = sa * sb;
                o = r[31:0];
            end
            OP_DIV, OP_MOD: begin
                if (sb == 0) e = 2'b10;
                else begin
                    r = (op == OP_DIV) ? sa / sb : sa % sb;
                    o = r[31:0];
                end
            end
            default: e = 2'b11;
        endcase
        return {e, o};
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [15:0] b);
        if (op == OP_MUL) return 17;
        if ((op == OP_DIV || op == OP_MOD) && b != 0) return 17;
        return 1;
    endfunction

    // One compare process: handshake, latency, result and hold-stability every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            expQ.delete();
            lastOut  = '0;
            lastErr  = '0;
            sawValid = 1'b0;
        end else begin
            checkOutput("in_ready", ifS.in_ready, expQ.size() == 0);
            if (expQ.size() == 0) begin
                checkOutput("idle_out_valid", ifS.out_valid, 0);
                checkOutput("hold_output1", ifS.output1, lastOut);
                checkOutput("hold_err", ifS.err_code, lastErr);
            end else begin
                e = expQ[0];
                if (!sawValid) begin
                    if (cyc - e.acc + 1 == e.lat) checkOutput("out_valid_on_time", ifS.out_valid, 1);
                    else                          checkOutput("out_valid_early_late", ifS.out_valid, 0);
                end
                if (ifS.out_valid) begin
                    sawValid = 1'b1;
                    checkOutput("model_output1", ifS.output1, e.o);
                    checkOutput("model_err", ifS.err_code, e.e);
                    lastOut = e.o;
                    lastErr = e.e;
                    if (ifS.out_ready) begin
                        void'(expQ.pop_front());
                        sawValid = 1'b0;
                    end
                end else begin
                    checkOutput("busy_hold_output1", ifS.output1, lastOut);
                    checkOutput("busy_hold_err", ifS.err_code, lastErr);
                end
            end
        end
    end

    task automatic waitInReady();
        int n = 0;
        while (!ifS.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_wait", ifS.in_ready, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [33:0] m;
        exp_t e;
        waitInReady();
        ifS.in_valid = 1'b1;
        ifS.op_code  = op;
        ifS.input1   = a;
        ifS.input2   = b;
        @(posedge clk); #1;
        m     = model(op, a, b, 1'b1);
        e.o   = m[31:0];
        e.e   = m[33:32];
        e.acc = cyc;
        e.lat = latency(op, b);
        expQ.push_back(e);
        ifS.in_valid = 1'b0;
        ifS.op_code  = 4'($urandom);
        ifS.input1   = 16'($urandom);
        ifS.input2   = 16'($urandom);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input int hold, output logic [31:0] got, output logic [1:0] gotErr);
        int n = 0;
        ifS.out_ready = (hold == 0);
        issue(op, a, b);
        while (!ifS.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("out_valid_wait", ifS.out_valid, 1);
        got    = ifS.output1;
        gotErr = ifS.err_code;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        ifS.out_ready = 1'b1;
        @(posedge clk); #1;
        ifS.out_ready = 1'b0;
    endtask

    task automatic applyUnsigned(input string name, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [31:0] wantOut, input logic [1:0] wantErr);
        int n = 0;
        while (!ifU.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ifU.in_valid = 1'b1;
        ifU.op_code  = op;
        ifU.input1   = a;
        ifU.input2   = b;
        @(posedge clk); #1;
        ifU.in_valid = 1'b0;
        n = 0;
        while (!ifU.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_out"}, ifU.output1, wantOut);
        checkOutput({name, "_err"}, ifU.err_code, wantErr);
        @(posedge clk); #1;
    endtask

    task automatic checkLiteral(input string name, input logic [31:0] got, input logic [1:0] gotErr,
                                input logic [31:0] wantOut, input logic [1:0] wantErr);
        checkOutput({name, "_out"}, got, wantOut);
        checkOutput({name, "_err"}, gotErr, wantErr);
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0]  gotErr;
        logic [3:0]  op;
        logic [15:0] a, b;
        int          sel;

        rst_n = 1'b0;
        ifS.in_valid = 1'b0; ifS.out_ready = 1'b0;
        ifS.op_code = '0; ifS.input1 = '0; ifS.input2 = '0;
        ifU.in_valid = 1'b0; ifU.out_ready = 1'b1;
        ifU.op_code = '0; ifU.input1 = '0; ifU.input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_in_ready", ifS.in_ready, 1);
        checkOutput("reset_out_valid", ifS.out_valid, 0);
        checkOutput("reset_output1", ifS.output1, 0);
        checkOutput("reset_err", ifS.err_code, 0);
        @(posedge clk); #1;

        applyStimulus(OP_MUL, 16'd11, 16'd15, 0, got, gotErr);
        checkLiteral("mul_11x15", got, gotErr, 32'd165, 2'b00);
        applyStimulus(OP_ADD, 16'd32000, 16'd16000, 0, got, gotErr);
        checkLiteral("add_ovf", got, gotErr, 32'd48000, 2'b01);
        applyStimulus(OP_SUB, 16'd11, 16'd15, 1, got, gotErr);
        checkLiteral("sub_neg", got, gotErr, 32'hFFFF_FFFC, 2'b00);
        applyStimulus(OP_DIV, 16'hFFF9, 16'd2, 0, got, gotErr);
        checkLiteral("div_m7_2", got, gotErr, 32'hFFFF_FFFD, 2'b00);
        applyStimulus(OP_MOD, 16'hFFF9, 16'd2, 0, got, gotErr);
        checkLiteral("mod_m7_2", got, gotErr, 32'hFFFF_FFFF, 2'b00);
        applyStimulus(OP_DIV, 16'h8000, 16'hFFFF, 2, got, gotErr);
        checkLiteral("div_min_m1", got, gotErr, 32'd32768, 2'b00);
        applyStimulus(OP_DIV, 16'd11, 16'd0, 0, got, gotErr);
        checkLiteral("div_by_zero", got, gotErr, 32'd0, 2'b10);
        applyStimulus(4'd7, 16'd5, 16'd3, 0, got, gotErr);
        checkLiteral("invalid_op", got, gotErr, 32'd0, 2'b11);
        applyStimulus(OP_MUL, 16'd32000, 16'd16000, 5, got, gotErr);
        checkLiteral("mul_held", got, gotErr, 32'd512000000, 2'b00);

        // Reset four cycles into a multiply must abort it outright.
        ifS.out_ready = 1'b1;
        issue(OP_MUL, 16'd123, 16'd45);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", ifS.out_valid, 0);
        checkOutput("abort_output1", ifS.output1, 0);
        checkOutput("abort_err", ifS.err_code, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        applyStimulus(OP_ADD, 16'd1, 16'd2, 0, got, gotErr);
        checkLiteral("add_after_reset", got, gotErr, 32'd3, 2'b00);

        applyUnsigned("u_div", OP_DIV, 16'hFFFF, 16'd2, 32'd32767, 2'b00);
        applyUnsigned("u_add_ovf", OP_ADD, 16'hFFFF, 16'd1, 32'd65536, 2'b01);
        applyUnsigned("u_mul", OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 2'b00);
        applyUnsigned("u_mod", OP_MOD, 16'd1000, 16'd7, 32'd6, 2'b00);

        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 11);
            op  = (sel < 10) ? 4'(sel % 5) : 4'($urandom_range(5, 15));
            a   = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'($urandom_range(1, 9));
                default: b = 16'($urandom);
            endcase
            applyStimulus(op, a, b, $urandom_range(0, 3), got, gotErr);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
